// File: rtl/attn_grad_v.sv
// Value-gradient engine dV = S^T * dO, one sequential MAC per cycle triple, dV streamed over valid/ready.
// Build option ATTN_GRAD_SAT_EN: saturate narrowed results instead of two's-complement wrap.
module attn_grad_v #(
  parameter int DATA_WIDTH = 16,
  parameter int SEQ_LEN    = 64,
  parameter int EMBED_DIM  = 64,
  parameter int FRAC_BITS  = 14
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic [DATA_WIDTH*SEQ_LEN*SEQ_LEN-1:0]     softmax_scores_flat,
  input  logic [DATA_WIDTH*SEQ_LEN*EMBED_DIM-1:0]   dout_flat,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [DATA_WIDTH-1:0]                     out_data,
  output logic [$clog2(SEQ_LEN)-1:0]                out_row,
  output logic [$clog2(EMBED_DIM)-1:0]              out_col,
  output logic                                      busy,
  output logic                                      done,
  output logic [2:0]                                debug_state
);

  localparam int IW  = $clog2(SEQ_LEN);
  localparam int KW  = $clog2(EMBED_DIM);
  localparam int PW  = 2 * DATA_WIDTH;
  localparam int AW  = PW + IW;
  localparam int SBW = $clog2(DATA_WIDTH * SEQ_LEN * SEQ_LEN);
  localparam int GBW = $clog2(DATA_WIDTH * SEQ_LEN * EMBED_DIM);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    MULT  = 3'd2,
    ACCUM = 3'd3,
    EMIT  = 3'd4
  } state_t;

  state_t                         state_q;
  logic [IW-1:0]                  i_q, j_q;
  logic [KW-1:0]                  k_q;
  logic signed [AW-1:0]           acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0]   s_q, g_q;
  logic signed [PW-1:0]           prod_q, prod_d, prod_sh;
  logic signed [AW-1:0]           term;
  logic                           out_valid_q, done_q;
  logic [DATA_WIDTH-1:0]          out_data_q, out_data_d;
  logic [SBW-1:0]                 s_base;
  logic [GBW-1:0]                 g_base;

  assign s_base  = SBW'((int'(i_q) * SEQ_LEN + int'(j_q)) * DATA_WIDTH);
  assign g_base  = GBW'((int'(i_q) * EMBED_DIM + int'(k_q)) * DATA_WIDTH);
  assign prod_d  = PW'(s_q) * PW'(g_q);
  assign prod_sh = prod_q >>> FRAC_BITS;
  assign term    = {{IW{prod_sh[PW-1]}}, prod_sh};
  assign acc_d   = acc_q + term;

`ifdef ATTN_GRAD_SAT_EN
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  always_comb begin
    out_data_d = acc_d[DATA_WIDTH-1:0];
    if (acc_d > SAT_MAX)
      out_data_d = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (acc_d < SAT_MIN)
      out_data_d = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  end
`else
  assign out_data_d = acc_d[DATA_WIDTH-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      s_q         <= '0;
      g_q         <= '0;
      prod_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            state_q <= READ;
          end
        end
        READ: begin
          s_q     <= softmax_scores_flat[s_base +: DATA_WIDTH];
          g_q     <= dout_flat[g_base +: DATA_WIDTH];
          state_q <= MULT;
        end
        MULT: begin
          prod_q  <= prod_d;
          state_q <= ACCUM;
        end
        ACCUM: begin
          acc_q <= acc_d;
          if (i_q != IW'(SEQ_LEN - 1)) begin
            i_q     <= i_q + IW'(1);
            state_q <= READ;
          end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= 1'b1;
            i_q         <= '0;
            state_q     <= EMIT;
          end
        end
        EMIT: begin
          // Row/col/data are held simply because nothing below moves until the handshake.
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            if (k_q != KW'(EMBED_DIM - 1)) begin
              k_q     <= k_q + KW'(1);
              state_q <= READ;
            end else if (j_q != IW'(SEQ_LEN - 1)) begin
              k_q     <= '0;
              j_q     <= j_q + IW'(1);
              state_q <= READ;
            end else begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_row     = j_q;
  assign out_col     = k_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign debug_state = state_q;

endmodule

// File: tb/tb_attn_grad_v.sv
// Directed bench for attn_grad_v at SEQ_LEN=EMBED_DIM=4; expected narrowing follows ATTN_GRAD_SAT_EN.
module tb_attn_grad_v;
  localparam int DW = 16;
  localparam int N  = 4;
  localparam int E  = 4;
  localparam int F  = 14;
  localparam int NE = N * E;
  localparam int BUDGET = 2000;

  logic           clk = 1'b0;
  logic           rst, start, out_ready;
  logic           out_valid, busy, done;
  logic [DW-1:0]  out_data;
  logic [1:0]     out_row, out_col;
  logic [2:0]     debug_state;
  logic [DW*N*N-1:0] s_flat;
  logic [DW*N*E-1:0] d_flat;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;
  logic [DW-1:0] exp_v [NE];
  logic [DW-1:0] got_d [NE];
  int            got_r [NE];
  int            got_c [NE];
  int            n_got;
  int            lat_done, lat_valid;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  attn_grad_v #(.DATA_WIDTH(DW), .SEQ_LEN(N), .EMBED_DIM(E), .FRAC_BITS(F)) dut (
    .clk(clk), .rst(rst), .start(start),
    .softmax_scores_flat(s_flat), .dout_flat(d_flat),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col),
    .busy(busy), .done(done), .debug_state(debug_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic fill(input logic [DW-1:0] sv, input logic [DW-1:0] dv);
    for (int i = 0; i < N * N; i++) s_flat[i*DW +: DW] = sv;
    for (int i = 0; i < N * E; i++) d_flat[i*DW +: DW] = dv;
  endtask

  task automatic load_identity();
    fill(16'h0000, 16'h0000);
    for (int i = 0; i < N; i++) s_flat[(i*N+i)*DW +: DW] = 16'h4000;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < E; k++) begin
        d_flat[(i*E+k)*DW +: DW] = 16'(16'h0100 * (4*i + k + 1));
        exp_v[i*E+k]             = 16'(16'h0100 * (4*i + k + 1));
      end
  endtask

  // Entered and left #1 after a rising edge.
  task automatic run_job(input bit bp);
    int ts, stall;
    bit held, seen11;
    logic [DW-1:0] hd;
    logic [1:0] hr, hc;
    n_got = 0; lat_done = -1; lat_valid = -1;
    held = 0; seen11 = 0; stall = 0; hd = '0; hr = '0; hc = '0;
    for (int n = 0; n < NE; n++) begin got_d[n] = 'x; got_r[n] = -1; got_c[n] = -1; end
    ts = cyc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < BUDGET; c++) begin
      if (c == 0) begin
        check("busy_after_start", busy, 1'b1);
        check("state_after_start", debug_state, 3'd1);
      end
      if (held) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_data", out_data, hd);
        check("hold_row", out_row, hr);
        check("hold_col", out_col, hc);
      end
      if (out_valid && lat_valid < 0) lat_valid = cyc - ts;
      if (done) begin
        lat_done = cyc - ts;
        check("busy_at_done", busy, 1'b0);
        break;
      end
      if (!bp) out_ready = 1'b1;
      else if (stall > 0) begin out_ready = 1'b0; stall--; end
      else if (out_valid && out_row == 2'd1 && out_col == 2'd1 && !seen11) begin
        seen11 = 1; stall = 9; out_ready = 1'b0;
      end else out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        if (n_got < NE) begin
          got_d[n_got] = out_data; got_r[n_got] = out_row; got_c[n_got] = out_col;
        end
        n_got++;
      end
      held = out_valid && !out_ready;
      hd = out_data; hr = out_row; hc = out_col;
      @(posedge clk); #1;
    end
    check("done_seen", lat_done >= 0, 1'b1);
    if (lat_done >= 0) begin
      @(posedge clk); #1;
      check("done_one_cycle", done, 1'b0);
    end
    out_ready = 1'b1;
  endtask

  task automatic verify(input string name, input bit chk_lat);
    check({name, "_count"}, n_got, NE);
    for (int n = 0; n < NE; n++) begin
      check({name, "_data"}, got_d[n], exp_v[n]);
      check({name, "_row"}, got_r[n], n / E);
      check({name, "_col"}, got_c[n], n % E);
    end
    if (chk_lat) begin
      check({name, "_lat_done"}, lat_done, 209);
      check({name, "_lat_valid"}, lat_valid, 13);
    end
  endtask

  initial begin
    logic [DW-1:0] n1, n2;
    bit found, saw_done;
`ifdef ATTN_GRAD_SAT_EN
    n1 = 16'h7FFF; n2 = 16'h8000;
`else
    n1 = 16'hFFF0; n2 = 16'h0008;
`endif
    rst = 1'b1; start = 1'b1; out_ready = 1'b1;
    fill(16'h0000, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0; rst = 1'b0;
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 16'h0000);
    check("rst_row", out_row, 2'd0);
    check("rst_col", out_col, 2'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_state", debug_state, 3'd0);

    load_identity();
    run_job(1'b0);
    verify("identity", 1'b1);

    fill(16'h0000, 16'h7000);
    s_flat[(0*N+1)*DW +: DW] = 16'h4000;
    d_flat[0*DW +: DW] = 16'h1000; d_flat[1*DW +: DW] = 16'h2000;
    d_flat[2*DW +: DW] = 16'hE000; d_flat[3*DW +: DW] = 16'h0400;
    for (int n = 0; n < NE; n++) exp_v[n] = 16'h0000;
    exp_v[4] = 16'h1000; exp_v[5] = 16'h2000; exp_v[6] = 16'hE000; exp_v[7] = 16'h0400;
    run_job(1'b0);
    verify("transpose", 1'b1);

    fill(16'h1000, 16'h4000);
    for (int n = 0; n < NE; n++) exp_v[n] = 16'h4000;
    run_job(1'b0);
    verify("uniform", 1'b1);

    load_identity();
    run_job(1'b1);
    verify("backpressure", 1'b0);

    fill(16'h7FFF, 16'h7FFF);
    for (int n = 0; n < NE; n++) exp_v[n] = n1;
    run_job(1'b0);
    verify("narrow_pos", 1'b0);

    fill(16'h7FFF, 16'h8000);
    for (int n = 0; n < NE; n++) exp_v[n] = n2;
    run_job(1'b0);
    verify("narrow_neg", 1'b0);

    load_identity();
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 0;
    for (int c = 0; c < BUDGET; c++) begin
      if (debug_state == 3'd3 && out_row == 2'd2 && out_col == 2'd3) begin found = 1; break; end
      @(posedge clk); #1;
    end
    check("midrun_accum_found", found, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrun_valid", out_valid, 1'b0);
    check("midrun_busy", busy, 1'b0);
    check("midrun_state", debug_state, 3'd0);
    check("midrun_done", done, 1'b0);
    check("midrun_data", out_data, 16'h0000);
    saw_done = 0;
    for (int c = 0; c < 20; c++) begin
      if (done || busy) saw_done = 1;
      @(posedge clk); #1;
    end
    check("midrun_stays_idle", saw_done, 1'b0);
    run_job(1'b0);
    verify("after_reset", 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
